alu_arbiter: RTL

Shares one combinational `alu` instance between two independent requesters, such as a fetch/branch unit and the execute stage. Each requester issues operand/opcode packets over a valid/ready handshake and receives result and flags over a second valid/ready handshake. Arbitration is round-robin with one operation in flight. The ALU's combinational path is isolated behind registers on both sides.

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional opcode check is enabled by defining ALU_ARB_OPCHK_EN.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [2:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [2:0]            req1_op,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_result,
  output logic [2:0]            resp0_flags,
  output logic                  resp0_err,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_result,
  output logic [2:0]            resp1_flags,
  output logic                  resp1_err,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  alu_carryout,
  input  logic                  alu_zero,
  output logic [1:0]            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and ready may depend combinationally on valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]            alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [2:0]            flags_q, flags_d;
  logic                  err_q, err_d;

  logic                  any_valid;
  logic                  grant_id;
  logic                  accept;
  logic                  illegal_op;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [2:0]            sel_op;

  // Grant: a lone requester always wins; on a tie the one that was not served last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid & req1_valid) grant_id = ~last_q;
    else                         grant_id = req1_valid;
    accept = (state_q == IDLE) & any_valid;
    sel_a  = grant_id ? req1_a  : req0_a;
    sel_b  = grant_id ? req1_b  : req0_b;
    sel_op = grant_id ? req1_op : req0_op;
`ifdef ALU_ARB_OPCHK_EN
    illegal_op = (sel_op == 3'b011) | (sel_op == 3'b100) | (sel_op == 3'b101);
`else
    illegal_op = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'b000;
      res_q    <= '0;
      flags_q  <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    flags_d  = flags_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant_id;
          last_d  = grant_id;
          if (illegal_op) begin
            // Rejected opcodes never reach the ALU; answer straight away.
            state_d = RESP;
            res_d   = '0;
            flags_d = 3'b000;
            err_d   = 1'b1;
          end else begin
            state_d  = ISSUE;
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
          end
        end
      end
      ISSUE: begin
        res_d   = alu_result;
        flags_d = {alu_overflow, alu_carryout, alu_zero};
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? resp1_ready : resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = rst_n & accept & ~grant_id;
    req1_ready   = rst_n & accept &  grant_id;
    resp0_valid  = (state_q == RESP) & ~owner_q;
    resp1_valid  = (state_q == RESP) &  owner_q;
    resp0_result = resp0_valid ? res_q   : '0;
    resp0_flags  = resp0_valid ? flags_q : 3'b000;
    resp0_err    = resp0_valid & err_q;
    resp1_result = resp1_valid ? res_q   : '0;
    resp1_flags  = resp1_valid ? flags_q : 3'b000;
    resp1_err    = resp1_valid & err_q;
    alu_a        = alu_a_q;
    alu_b        = alu_b_q;
    alu_op       = alu_op_q;
    dbg_state    = state_q;
  end

endmodule
